// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: grant owner and the
// round-robin tie-break rule.
package mem_arbiter_pkg;

  typedef enum logic {
    GRANT_INSTR = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_t;

  // On a tie the requester that did not win last time is served.
  function automatic grant_t tie_winner(input grant_t last_grant);
    return (last_grant == GRANT_INSTR) ? GRANT_DATA : GRANT_INSTR;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction and a
// data requester; one FSM plus a combinational output mux.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  input  logic        q_m_ack,
  input  logic [15:0] q_m_data_in
);

  // Handshake: a requester holds access until its ack; ack is q_m_ack passed
  // through in the same cycle, only to the granted side, only while serving.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SERVE_INSTR = 2'd1,
    SERVE_DATA  = 2'd2
  } state_t;

  state_t state, state_next;
  grant_t last_grant, last_grant_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GRANT_INSTR;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (instr_m_access && data_m_access) begin
          last_grant_next = tie_winner(last_grant);
          state_next = (tie_winner(last_grant) == GRANT_DATA) ? SERVE_DATA : SERVE_INSTR;
        end else if (data_m_access) begin
          last_grant_next = GRANT_DATA;
          state_next      = SERVE_DATA;
        end else if (instr_m_access) begin
          last_grant_next = GRANT_INSTR;
          state_next      = SERVE_INSTR;
        end
      end
      // Completion or abort both end the grant; an IDLE cycle always follows.
      SERVE_INSTR: if (!instr_m_access || q_m_ack) state_next = IDLE;
      SERVE_DATA:  if (!data_m_access || q_m_ack) state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (state)
      SERVE_INSTR: begin
        q_m_addr    = instr_m_addr;
        q_m_access  = instr_m_access;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
      end
      SERVE_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
      end
      default: ;
    endcase
  end

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for reset,
// tie-break and abort corners, then random traffic against a reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam logic [19:1] IA = 19'h0AAAA;
  localparam logic [19:1] DA = 19'h00010;
  localparam logic [15:0] WD = 16'h1234;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:1] instr_m_addr = '0;
  logic        instr_m_access = 1'b0;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [19:1] data_m_addr = '0;
  logic [15:0] data_m_data_out = '0;
  logic        data_m_access = 1'b0;
  logic        data_m_wr_en = 1'b0;
  logic [1:0]  data_m_bytesel = 2'b00;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_ack = 1'b0;
  logic [15:0] q_m_data_in = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack),
    .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_access(q_m_access),
    .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel), .q_m_ack(q_m_ack),
    .q_m_data_in(q_m_data_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ia, da, wr, qk;
    logic [1:0]  bs;
    logic [15:0] qd;
    logic        e_iack, e_dack, e_qacc, e_wr;
    logic [1:0]  e_bs;
    logic [19:1] e_addr;
    logic [15:0] e_dout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_iack, input logic e_dack,
                           input logic e_qacc, input logic e_wr, input logic [1:0] e_bs,
                           input logic [19:1] e_addr, input logic [15:0] e_dout,
                           input logic [15:0] e_rd);
    check({tag, ".instr_ack"}, 32'(instr_m_ack), 32'(e_iack));
    check({tag, ".data_ack"},  32'(data_m_ack),  32'(e_dack));
    check({tag, ".q_access"},  32'(q_m_access),  32'(e_qacc));
    check({tag, ".q_wr_en"},   32'(q_m_wr_en),   32'(e_wr));
    check({tag, ".q_bytesel"}, 32'(q_m_bytesel), 32'(e_bs));
    check({tag, ".q_addr"},    32'(q_m_addr),    32'(e_addr));
    check({tag, ".q_dout"},    32'(q_m_data_out), 32'(e_dout));
    check({tag, ".instr_rd"},  32'(instr_m_data_in), 32'(e_rd));
    check({tag, ".data_rd"},   32'(data_m_data_in),  32'(e_rd));
  endtask

  // Called at a falling edge: drive, settle, compare, advance one cycle.
  task automatic apply_vec(input vec_t v, input string tag);
    instr_m_addr    = IA;
    data_m_addr     = DA;
    data_m_data_out = WD;
    instr_m_access  = v.ia;
    data_m_access   = v.da;
    data_m_wr_en    = v.wr;
    data_m_bytesel  = v.bs;
    q_m_ack         = v.qk;
    q_m_data_in     = v.qd;
    #1;
    check_all(tag, v.e_iack, v.e_dack, v.e_qacc, v.e_wr, v.e_bs, v.e_addr, v.e_dout, v.qd);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    instr_m_access = 1'b0;
    data_m_access  = 1'b0;
    q_m_ack        = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[12];
  vec_t v;
  vec_t idle_v;

  // Reference model state: who owns the port (0 none, 1 instr, 2 data).
  int     m_owner;
  grant_t m_last;

  initial begin
    idle_v = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0,
               1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0};

    //         ia    da    wr    qk    bs     qd          ei    ed    eq    ew    ebs    eaddr eDout
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, DA,    WD};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, DA,    WD};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, DA,    WD};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, DA,    WD};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, DA,    WD};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, IA,    16'h0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 16'h5A5A, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, IA,    16'h0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0};

    // Reset state: outputs quiet while reset is held.
    @(negedge clk);
    apply_vec(idle_v, "reset_hold");
    reset = 1'b1;

    // Data read, then a data write with an instruction request pending.
    for (int i = 0; i < 12; i++) apply_vec(tbl[i], $sformatf("tbl%0d", i));

    // Simultaneous requests after reset: D,I,D,I with an IDLE cycle between.
    // q_m_ack stays high throughout, so IDLE cycles also see a spurious ack.
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      v = idle_v;
      v.ia = 1'b1; v.da = 1'b1; v.qk = 1'b1; v.qd = 16'(16'hA000 + i);
      if (i % 2 == 1) begin
        v.e_qacc = 1'b1;
        v.e_bs   = 2'b11;
        if (((i / 2) % 2) == 0) begin
          v.e_dack = 1'b1; v.e_addr = DA; v.e_dout = WD;
        end else begin
          v.e_iack = 1'b1; v.e_addr = IA;
        end
      end
      apply_vec(v, $sformatf("rr%0d", i));
    end

    // Abort of a data grant, then a tie must go to instr.
    v = idle_v; v.da = 1'b1;
    apply_vec(v, "abort_req");
    v.e_qacc = 1'b1; v.e_bs = 2'b11; v.e_addr = DA; v.e_dout = WD;
    apply_vec(v, "abort_serve");
    v.da = 1'b0; v.e_qacc = 1'b0;
    apply_vec(v, "abort_drop");
    v = idle_v; v.ia = 1'b1; v.da = 1'b1;
    apply_vec(v, "abort_idle");
    v.qk = 1'b1; v.e_iack = 1'b1; v.e_qacc = 1'b1; v.e_bs = 2'b11; v.e_addr = IA;
    apply_vec(v, "abort_tie");
    apply_vec(idle_v, "abort_after");

    // Reset pulsed in the middle of an instruction grant.
    v = idle_v; v.ia = 1'b1;
    apply_vec(v, "mid_req");
    #1;
    check("mid_serving.q_access", 32'(q_m_access), 32'd1);
    #1;
    reset = 1'b0;
    q_m_ack = 1'b1;
    #1;
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 19'h0, 16'h0, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    v = idle_v; v.qk = 1'b1;
    apply_vec(v, "mid_after0");
    apply_vec(v, "mid_after1");

    // Random traffic against the reference model.
    pulse_reset();
    m_owner = 0;
    m_last  = GRANT_INSTR;
    for (int c = 0; c < 400; c++) begin
      logic e_iack, e_dack, e_qacc, e_wr;
      logic [1:0] e_bs;
      logic [19:1] e_addr;
      logic [15:0] e_dout;
      instr_m_addr    = 19'($urandom);
      data_m_addr     = 19'($urandom);
      data_m_data_out = 16'($urandom);
      instr_m_access  = ($urandom_range(0, 3) != 0);
      data_m_access   = ($urandom_range(0, 3) != 0);
      data_m_wr_en    = 1'($urandom);
      data_m_bytesel  = 2'($urandom);
      q_m_ack         = ($urandom_range(0, 2) == 0);
      q_m_data_in     = 16'($urandom);
      #1;
      e_iack = 1'b0; e_dack = 1'b0; e_qacc = 1'b0; e_wr = 1'b0;
      e_bs = 2'b00; e_addr = '0; e_dout = '0;
      if (m_owner == 1) begin
        e_iack = q_m_ack; e_qacc = instr_m_access; e_bs = 2'b11; e_addr = instr_m_addr;
      end else if (m_owner == 2) begin
        e_dack = q_m_ack; e_qacc = data_m_access; e_wr = data_m_wr_en;
        e_bs = data_m_bytesel; e_addr = data_m_addr; e_dout = data_m_data_out;
      end
      check_all($sformatf("rnd%0d", c), e_iack, e_dack, e_qacc, e_wr, e_bs, e_addr, e_dout,
                q_m_data_in);
      if (m_owner == 0) begin
        if (instr_m_access && data_m_access) m_owner = (m_last == GRANT_INSTR) ? 2 : 1;
        else if (data_m_access)              m_owner = 2;
        else if (instr_m_access)             m_owner = 1;
        if (m_owner != 0) m_last = (m_owner == 2) ? GRANT_DATA : GRANT_INSTR;
      end else if (m_owner == 1) begin
        if (!instr_m_access || q_m_ack) m_owner = 0;
      end else begin
        if (!data_m_access || q_m_ack) m_owner = 0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 instr_m_addr  input  [19:1]  instruction requester word address.
REQ-005 instr_m_access  input  1  instruction request, held until acked.
REQ-006 instr_m_ack  output  1  instruction transfer complete.
REQ-007 instr_m_data_in  output  16  read data to instruction requester.
REQ-008 data_m_addr  input  [19:1]  data requester word address.
REQ-009 data_m_data_out  input  16  data requester write data.
REQ-010 data_m_access  input  1  data request, held until acked.
REQ-011 data_m_wr_en  input  1  data request is a write.
REQ-012 data_m_bytesel  input  2  data byte lanes, bit0 = low byte.
REQ-013 data_m_ack  output  1  data transfer complete.
REQ-014 data_m_data_in  output  16  read data to data requester.
REQ-015 q_m_addr  output  [19:1]  shared-port word address.
REQ-016 q_m_data_out  output  16  shared-port write data.
REQ-017 q_m_access  output  1  shared-port request.
REQ-018 q_m_wr_en  output  1  shared-port write strobe.
REQ-019 q_m_bytesel  output  2  shared-port byte lanes.
REQ-020 q_m_ack  input  1  shared-port transfer complete.
REQ-021 q_m_data_in  input  16  shared-port read data.

Function
REQ-022 FSM states SHALL be IDLE, SERVE_INSTR and SERVE_DATA; a 1-bit last_grant register SHALL record the most recently granted requester.
REQ-023 IDLE: only data_m_access high -> SERVE_DATA; only instr_m_access high -> SERVE_INSTR; neither high -> stay in IDLE.
REQ-024 IDLE with both high: grant the requester not equal to last_grant, i.e. round-robin, so that neither requester starves.
REQ-025 last_grant SHALL update on the IDLE->SERVE transition.
REQ-026 Arbitration latency SHALL be exactly one cycle: q_m_access is first high in the cycle after the request is sampled in IDLE.
REQ-027 In SERVE_x, the q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel and q_m_access outputs SHALL combinationally follow the granted requester's inputs; the instruction side SHALL drive q_m_wr_en=0, q_m_data_out=0 and q_m_bytesel=2'b11.
REQ-028 In IDLE, all q_m_* outputs SHALL be 0.
REQ-029 q_m_ack SHALL be forwarded combinationally, in the same cycle, to the granted requester's ack only; the other ack SHALL stay 0.
REQ-030 instr_m_data_in and data_m_data_in SHALL both carry q_m_data_in unconditionally; the ack qualifies which one is valid.
REQ-031 q_m_ack in SERVE_x SHALL return the FSM to IDLE on the next cycle; every grant SHALL be followed by one IDLE cycle.
REQ-032 A requester still asserting access in that IDLE cycle SHALL be treated as a new request and arbitrated normally.
REQ-033 q_m_ack while in IDLE SHALL be ignored; no ack SHALL be forwarded.
REQ-034 If the granted requester drops access before ack (abort), q_m_access SHALL follow it low and the FSM SHALL return to IDLE next cycle; last_grant SHALL be unchanged by the abort.
REQ-035 A non-granted request SHALL be held pending with no side effects until granted.

Reset
REQ-036 reset low SHALL asynchronously force the FSM to IDLE and last_grant to INSTR, so that data wins the first tie.
REQ-037 While reset is low and after its release, all outputs SHALL be 0 until the first grant.
REQ-038 Reset asserted mid-transaction SHALL abandon the transaction immediately; no ack SHALL be forwarded after reset asserts.

Structure
REQ-039 The grant-owner enum (GRANT_INSTR, GRANT_DATA) SHALL live in the shared package, for use by Core and the bench.
REQ-040 The FSM state enum SHALL be local to mem_arbiter.
REQ-041 No sub-module SHALL be used; the block is one FSM plus an output mux.
REQ-042 Core SHALL instantiate mem_arbiter between its Prefetch/LoadStore ports and a single external memory port.

Verification
REQ-043 Data-only read: data_m_access=1, addr=19'h00010, ack after 2 cycles with q_m_data_in=16'hBEEF -> q_m_access high at cycle +1; data_m_ack=1 with data 16'hBEEF; instr_m_ack=0 throughout.
REQ-044 Simultaneous requests after reset -> data granted first; then, with both still requesting, instr granted; grants alternate D,I,D,I over 4 transfers.
REQ-045 Instruction request while a data write is in progress (wr_en=1, bytesel=2'b10, data 16'h1234) -> instr held with no ack; q_m_* shows the data write unchanged until ack; instr granted two cycles after the data ack.
REQ-046 Abort: data_m_access dropped in SERVE_DATA before ack -> q_m_access=0 same cycle, FSM returns to IDLE, no acks; a later tie still grants instr if last_grant=DATA.
REQ-047 Spurious q_m_ack in IDLE -> both acks stay 0; reset pulsed low mid-SERVE_INSTR -> all outputs 0 immediately; after reset releases, no ack is forwarded for the abandoned transfer.
